clock_set_ctrl: RTL
===================

Name: clock_set_ctrl

Overview:
Timekeeping and time-set controller for the digital clock core. It owns the hour/minute/second registers and a 1 Hz prescaler. A mode/cursor state machine lets the user enter set mode, pick a field with LEFT/RIGHT, and step it with UP/DOWN, including hold-to-auto-repeat. Its outputs drive the display datapath directly.

Parameters:
CLK_HZ, 50000000, i_clk cycles per second tick (>=2)
REPEAT_DLY, 25000000, cycles UP/DOWN must be held after the press step before auto-repeat starts (>=1)
REPEAT_PER, 5000000, cycles between auto-repeat steps (>=1)

Ports:
i_clk  input  1  system clock
i_rstn  input  1  asynchronous active-low reset
i_mode  input  1  mode button level, synchronized upstream
i_up  input  1  increment button level
i_down  input  1  decrement button level
i_left  input  1  cursor-left button level
i_right  input  1  cursor-right button level
o_sec  output  6  seconds 0..59
o_min  output  6  minutes 0..59
o_hr  output  5  hours 0..23
o_setting  output  1  1 when in any SET state
o_field  output  2  selected field: 0 none, 1 sec, 2 min, 3 hr
o_tick  output  1  one-cycle pulse on each counted second

Behaviour:
- One clock; reset is asynchronous and active-low on i_rstn. All state is clocked on i_clk rising edge and cleared asynchronously when i_rstn=0.
- Reset values: o_sec=0, o_min=0, o_hr=0, o_setting=0, o_field=0, o_tick=0, prescaler=0, repeat counter=0, button history registers=0. A button held through reset deasserting does not produce a press.
- Press = rising edge of a button level, registered against the previous cycle's level. A press acts one cycle after the edge is sampled.
- States: RUN, SET_HR, SET_MIN, SET_SEC. o_setting=(state!=RUN). o_field gives 3/2/1 in the SET states and 0 in RUN.
- RUN:
  - The prescaler counts 0..CLK_HZ-1. On wrap, o_tick pulses for one cycle and the time advances by one second.
  - Carries: sec 59->0 increments min; min 59->0 increments hr; 23:59:59 -> 00:00:00.
  - UP/DOWN/LEFT/RIGHT presses are ignored.
- mode press:
  - RUN -> SET_HR. The prescaler is cleared and frozen, and o_tick stays 0 for the whole SET stay.
  - Any SET state -> RUN. The prescaler restarts from 0, so the first tick comes exactly CLK_HZ cycles after the exit cycle.
- LEFT press: SET_SEC->SET_MIN->SET_HR->SET_SEC. RIGHT press walks the reverse cycle.
- UP/DOWN step only the selected field by +/-1, with wrap and no carry:
  - sec/min: 59 up -> 0, 0 down -> 59.
  - hr: 23 up -> 0, 0 down -> 23.
- Auto-repeat:
  - A press gives one step immediately.
  - If the same button stays high for REPEAT_DLY further cycles, one step is applied, then another every REPEAT_PER cycles while it stays high.
  - Release, a mode press, a LEFT/RIGHT move, or reset clears the repeat counter.
- Simultaneous events:
  - A mode press in the same cycle as any other press: mode wins and the others are dropped.
  - UP and DOWN both high: no step, and repeat is cleared.
  - LEFT and RIGHT pressed in the same cycle: cursor unchanged.
  - A cursor move together with an UP/DOWN press: the step applies to the field selected before the move, then the cursor moves.
- Reset mid-operation (SET state or during auto-repeat) returns to RUN at 00:00:00 immediately.

Test Plan:
- CLK_HZ=4: release reset, run 16 cycles -> o_tick pulses on cycles 4,8,12,16; o_sec=4, o_min=0, o_hr=0, o_setting=0.
- Preload 23:59:58 via SET (hr DOWN from 0 ->23, min DOWN ->59, sec DOWN x2 ->58), mode press -> RUN, 8 cycles -> 00:00:00, with no tick before the 4th cycle after exit.
- In SET_HR: LEFT press -> o_field=1 (sec); RIGHT press -> 3 (hr); LEFT+RIGHT in the same cycle -> stays 3; UP+DOWN together -> o_hr unchanged.
- REPEAT_DLY=8, REPEAT_PER=2, SET_MIN, min=57: hold UP for 13 cycles after the edge -> steps at press, +8, +10, +12, so o_min goes 58,59,0,1 with no hr change.
- mode press together with UP in SET_SEC -> state RUN, o_sec unchanged, o_setting=0; UP/DOWN/LEFT/RIGHT presses in RUN -> no change to time or o_field.
- Assert i_rstn=0 mid-auto-repeat in SET_HR at 12:34:56 -> all outputs 0 asynchronously; button still high at release -> no step.

Source files
------------

// File: rtl/clock_set_ctrl.sv
// Clock timekeeping and time-set controller.
// Owns h/m/s registers, the 1 Hz prescaler and the set-mode cursor FSM.
module clock_set_ctrl #(
    parameter int CLK_HZ     = 50000000,
    parameter int REPEAT_DLY = 25000000,
    parameter int REPEAT_PER = 5000000
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_mode,
    input  logic       i_up,
    input  logic       i_down,
    input  logic       i_left,
    input  logic       i_right,
    output logic [5:0] o_sec,
    output logic [5:0] o_min,
    output logic [4:0] o_hr,
    output logic       o_setting,
    output logic [1:0] o_field,
    output logic       o_tick
);
    localparam int PW   = $clog2(CLK_HZ);
    localparam int RMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int RW   = $clog2(RMAX + 1);

    localparam logic [PW-1:0] PRE_TOP = PW'(CLK_HZ - 1);
    localparam logic [RW-1:0] DLY_V   = RW'(REPEAT_DLY);
    localparam logic [RW-1:0] PER_V   = RW'(REPEAT_PER);

    localparam int B_MODE = 4;
    localparam int B_UP   = 3;
    localparam int B_DN   = 2;
    localparam int B_LT   = 1;
    localparam int B_RT   = 0;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_SEC = 2'd1,
        SET_MIN = 2'd2,
        SET_HR  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [PW-1:0] pre_cnt;
    logic [RW-1:0] rpt_cnt;
    logic [RW-1:0] rpt_lim;
    logic          rpt_on;
    logic          rpt_per;
    logic          rpt_dn;
    logic          armed;
    logic [4:0]    btn;
    logic [4:0]    btn_q;
    logic [4:0]    btn_qq;
    logic [4:0]    press;
    logic          both_ud;
    logic          mv_l;
    logic          mv_r;
    logic          rpt_hold;
    logic          rpt_fire;
    logic          step_up;
    logic          step_dn;
    logic [5:0]    sec_w;
    logic [5:0]    min_w;
    logic [4:0]    hr_w;

    assign btn      = {i_mode, i_up, i_down, i_left, i_right};
    assign press    = btn_q & ~btn_qq;
    assign both_ud  = btn_q[B_UP] & btn_q[B_DN];
    assign mv_l     = press[B_LT] & ~press[B_RT];
    assign mv_r     = press[B_RT] & ~press[B_LT];
    assign rpt_hold = rpt_on & (rpt_dn ? btn_q[B_DN] : btn_q[B_UP]);
    assign rpt_lim  = rpt_per ? PER_V : DLY_V;
    assign rpt_fire = rpt_hold & (rpt_cnt == rpt_lim);

    always_comb begin
        step_up = 1'b0;
        step_dn = 1'b0;
        if (state != RUN && !press[B_MODE] && !both_ud) begin
            if (press[B_UP]) begin
                step_up = 1'b1;
            end else if (press[B_DN]) begin
                step_dn = 1'b1;
            end else if (rpt_fire) begin
                step_up = ~rpt_dn;
                step_dn = rpt_dn;
            end
        end
    end

    // Wrapped +/-1 candidates; only the selected field takes its value.
    always_comb begin
        sec_w = o_sec;
        min_w = o_min;
        hr_w  = o_hr;
        if (step_up) begin
            sec_w = (o_sec == 6'd59) ? 6'd0 : o_sec + 6'd1;
            min_w = (o_min == 6'd59) ? 6'd0 : o_min + 6'd1;
            hr_w  = (o_hr == 5'd23) ? 5'd0 : o_hr + 5'd1;
        end else if (step_dn) begin
            sec_w = (o_sec == 6'd0) ? 6'd59 : o_sec - 6'd1;
            min_w = (o_min == 6'd0) ? 6'd59 : o_min - 6'd1;
            hr_w  = (o_hr == 5'd0) ? 5'd23 : o_hr - 5'd1;
        end
    end

    always_comb begin
        state_nx = state;
        if (press[B_MODE]) begin
            state_nx = (state == RUN) ? SET_HR : RUN;
        end else if (state != RUN && (mv_l || mv_r)) begin
            unique case (state)
                SET_SEC: state_nx = mv_l ? SET_MIN : SET_HR;
                SET_MIN: state_nx = mv_l ? SET_HR : SET_SEC;
                SET_HR:  state_nx = mv_l ? SET_SEC : SET_MIN;
                default: state_nx = state;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state     <= RUN;
            pre_cnt   <= '0;
            rpt_cnt   <= '0;
            rpt_on    <= 1'b0;
            rpt_per   <= 1'b0;
            rpt_dn    <= 1'b0;
            armed     <= 1'b0;
            btn_q     <= '0;
            btn_qq    <= '0;
            o_sec     <= '0;
            o_min     <= '0;
            o_hr      <= '0;
            o_setting <= 1'b0;
            o_field   <= '0;
            o_tick    <= 1'b0;
        end else begin
            // First sample after reset seeds both stages so held buttons are not presses.
            armed     <= 1'b1;
            btn_q     <= btn;
            btn_qq    <= armed ? btn_q : btn;
            state     <= state_nx;
            o_setting <= (state_nx != RUN);
            o_field   <= state_nx;
            o_tick    <= 1'b0;
            if (state == RUN) begin
                rpt_on  <= 1'b0;
                rpt_per <= 1'b0;
                rpt_cnt <= '0;
                if (press[B_MODE]) begin
                    pre_cnt <= '0;
                end else if (pre_cnt == PRE_TOP) begin
                    pre_cnt <= '0;
                    o_tick  <= 1'b1;
                    if (o_sec == 6'd59) begin
                        o_sec <= '0;
                        if (o_min == 6'd59) begin
                            o_min <= '0;
                            o_hr  <= (o_hr == 5'd23) ? 5'd0 : o_hr + 5'd1;
                        end else begin
                            o_min <= o_min + 6'd1;
                        end
                    end else begin
                        o_sec <= o_sec + 6'd1;
                    end
                end else begin
                    pre_cnt <= pre_cnt + 1'b1;
                end
            end else begin
                pre_cnt <= '0;
                if (state == SET_SEC) o_sec <= sec_w;
                if (state == SET_MIN) o_min <= min_w;
                if (state == SET_HR)  o_hr  <= hr_w;
                if (press[B_MODE] || both_ud || mv_l || mv_r) begin
                    rpt_on  <= 1'b0;
                    rpt_per <= 1'b0;
                    rpt_cnt <= '0;
                end else if (press[B_UP] || press[B_DN]) begin
                    rpt_on  <= 1'b1;
                    rpt_per <= 1'b0;
                    rpt_dn  <= ~press[B_UP];
                    rpt_cnt <= RW'(1);
                end else if (rpt_hold) begin
                    if (rpt_fire) begin
                        rpt_per <= 1'b1;
                        rpt_cnt <= RW'(1);
                    end else begin
                        rpt_cnt <= rpt_cnt + 1'b1;
                    end
                end else begin
                    rpt_on  <= 1'b0;
                    rpt_per <= 1'b0;
                    rpt_cnt <= '0;
                end
            end
        end
    end
endmodule
